exu_issue_ctrl: RTL and testbench

Issue sequencer between decode and the execute datapath. Accepts one operation at a time over a valid/ready handshake and classifies it by ALU opcode as single-cycle (ALU/branch), multiply, or divide/remainder. It pulses the matching unit's start, waits for that unit's done, then holds the result selection until writeback accepts it. It also enforces a watchdog timeout and aborts the operation on pipeline flush.

---
 rtl/exu_pkg.sv | 46 ++++
 rtl/exu_watchdog.sv | 27 ++
 rtl/exu_issue_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_exu_issue_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_pkg.sv
// Shared types and opcode decode for the execute issue sequencer.
// EXU_DIV_EN enables the divider path; ALUOP_WIDTH defaults to 5 when not set.
`ifndef ALUOP_WIDTH
`define ALUOP_WIDTH 5
`endif

package exu_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_FU  = 3'd1,
    WAIT_MUL = 3'd2,
`ifdef EXU_DIV_EN
    WAIT_DIV = 3'd3,
`endif
    RESP     = 3'd4
  } exu_state_e;

  typedef enum logic [1:0] {
    SEL_ALU = 2'd0,
    SEL_MUL = 2'd1,
    SEL_QUO = 2'd2,
    SEL_REM = 2'd3
  } exu_sel_e;

  typedef enum logic [1:0] {
    CLS_FU  = 2'd0,
    CLS_MUL = 2'd1,
    CLS_DIV = 2'd2
  } exu_cls_e;

  localparam logic [31:0] OP_MUL  = 32'd15;
  localparam logic [31:0] OP_DIV  = 32'd16;
  localparam logic [31:0] OP_DIVU = 32'd17;
  localparam logic [31:0] OP_REM  = 32'd18;
  localparam logic [31:0] OP_REMU = 32'd19;

  function automatic exu_cls_e op_class(input logic [31:0] aluop);
    case (aluop)
      OP_MUL:                          return CLS_MUL;
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: return CLS_DIV;
      default:                         return CLS_FU;
    endcase
  endfunction

endpackage

// File: rtl/exu_watchdog.sv
// Wait-cycle counter; expired_o flags when the count reaches TIMEOUT_CYCLES.
module exu_watchdog #(
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  logic [9:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 10'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == 10'(TIMEOUT_CYCLES));

endmodule

// File: rtl/exu_issue_ctrl.sv
// Issue sequencer: start one functional unit, wait for done/timeout/flush, hold result for writeback.
// Build option EXU_DIV_EN: when undefined, div/rem opcodes complete immediately as illegal.
`ifndef ALUOP_WIDTH
`define ALUOP_WIDTH 5
`endif

module exu_issue_ctrl
  import exu_pkg::*;
#(
  parameter int ALUOP_WIDTH    = `ALUOP_WIDTH,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ALUOP_WIDTH-1:0] in_aluop,
  input  logic                   flush,
  output logic                   fu_valid,
  input  logic                   fu_done,
  output logic                   mul_start,
  input  logic                   mul_done,
  output logic                   div_start,
  output logic                   div_signed,
  input  logic                   div_done,
  output logic                   fu_kill,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_sel,
  output logic                   out_timeout,
  output logic                   out_illegal,
  output logic                   busy
);

  exu_state_e state_q, state_d;
  exu_sel_e   sel_q, sel_d;
  logic       fu_valid_q, fu_valid_d, mul_start_q, mul_start_d;
  logic       kill_q, kill_d, ovld_q, ovld_d, busy_q, busy_d;
  logic       tmo_q, tmo_d, ill_q, ill_d;
  logic       wd_clr, wd_inc, wd_expired, unit_done;
  logic       div_start_q, div_start_d, div_signed_q, div_signed_d;

  logic [31:0] op_w;
  exu_cls_e    cls;
  logic        is_rem;

  assign op_w   = 32'(in_aluop);
  assign cls    = op_class(op_w);
  assign is_rem = (op_w == OP_REM) || (op_w == OP_REMU);

`ifdef EXU_DIV_EN
  logic is_signed;
  assign is_signed = (op_w == OP_DIV) || (op_w == OP_REM);
`else
  logic unused_div_done;
  assign unused_div_done = div_done;
`endif

  assign in_ready = (state_q == IDLE) && !flush && !rst;

  exu_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wd_clr),
    .inc_i     (wd_inc),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    tmo_d        = tmo_q;
    ill_d        = ill_q;
    fu_valid_d   = 1'b0;
    mul_start_d  = 1'b0;
    div_start_d  = 1'b0;
    div_signed_d = 1'b0;
    kill_d       = 1'b0;
    wd_clr       = 1'b0;
    wd_inc       = 1'b0;
    unit_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          wd_clr = 1'b1;
          tmo_d  = 1'b0;
          ill_d  = 1'b0;
          case (cls)
            CLS_MUL: begin
              state_d     = WAIT_MUL;
              mul_start_d = 1'b1;
              sel_d       = SEL_MUL;
            end
            CLS_DIV: begin
              if (is_rem) sel_d = SEL_REM;
              else        sel_d = SEL_QUO;
`ifdef EXU_DIV_EN
              state_d      = WAIT_DIV;
              div_start_d  = 1'b1;
              div_signed_d = is_signed;
`else
              state_d = RESP;
              ill_d   = 1'b1;
`endif
            end
            default: begin
              state_d    = WAIT_FU;
              fu_valid_d = 1'b1;
              sel_d      = SEL_ALU;
            end
          endcase
        end
      end
`ifdef EXU_DIV_EN
      WAIT_FU, WAIT_MUL, WAIT_DIV: begin
`else
      WAIT_FU, WAIT_MUL: begin
`endif
        wd_inc = 1'b1;
        // start pulse is high only in the first WAIT cycle, so it masks done there
        if (state_q == WAIT_FU)       unit_done = fu_done && !fu_valid_q;
        else if (state_q == WAIT_MUL) unit_done = mul_done && !mul_start_q;
`ifdef EXU_DIV_EN
        else                          unit_done = div_done && !div_start_q;
`endif
        if (flush) begin
          state_d = IDLE;
          kill_d  = 1'b1;
        end else if (unit_done) begin
          state_d = RESP;
          tmo_d   = 1'b0;
        end else if (wd_expired) begin
          state_d = RESP;
          tmo_d   = 1'b1;
          kill_d  = 1'b1;
        end
      end
      RESP: if (flush || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ovld_d = (state_d == RESP);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= SEL_ALU;
      tmo_q        <= 1'b0;
      ill_q        <= 1'b0;
      fu_valid_q   <= 1'b0;
      mul_start_q  <= 1'b0;
      div_start_q  <= 1'b0;
      div_signed_q <= 1'b0;
      kill_q       <= 1'b0;
      ovld_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      tmo_q        <= tmo_d;
      ill_q        <= ill_d;
      fu_valid_q   <= fu_valid_d;
      mul_start_q  <= mul_start_d;
      div_start_q  <= div_start_d;
      div_signed_q <= div_signed_d;
      kill_q       <= kill_d;
      ovld_q       <= ovld_d;
      busy_q       <= busy_d;
    end
  end

  assign fu_valid    = fu_valid_q;
  assign mul_start   = mul_start_q;
  assign div_start   = div_start_q;
  assign div_signed  = div_signed_q;
  assign fu_kill     = kill_q;
  assign out_valid   = ovld_q;
  assign out_sel     = sel_q;
  assign out_timeout = tmo_q;
  assign out_illegal = ill_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// Scenario bench for exu_issue_ctrl; a second instance with a short watchdog covers timeout cases.
module tb_exu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, flush, fu_done, mul_done, div_done, out_ready;
  logic [4:0] in_aluop;
  logic       in_ready, fu_valid, mul_start, div_start, div_signed, fu_kill;
  logic       out_valid, out_timeout, out_illegal, busy;
  logic [1:0] out_sel;

  logic       t_in_valid, t_mul_done, t_out_ready;
  logic [4:0] t_in_aluop;
  logic       t_in_ready, t_fu_valid, t_mul_start, t_div_start, t_div_signed, t_fu_kill;
  logic       t_out_valid, t_out_timeout, t_out_illegal, t_busy;
  logic [1:0] t_out_sel;

  int checks = 0;
  int failures = 0;
  logic div_start_seen = 1'b0;

  typedef struct packed {logic [1:0] sel; logic tmo; logic ill;} exp_t;
  exp_t sb[$];
  exp_t got, want;

  exu_issue_ctrl #(.ALUOP_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
    .flush(flush), .fu_valid(fu_valid), .fu_done(fu_done), .mul_start(mul_start),
    .mul_done(mul_done), .div_start(div_start), .div_signed(div_signed), .div_done(div_done),
    .fu_kill(fu_kill), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
    .out_timeout(out_timeout), .out_illegal(out_illegal), .busy(busy)
  );

  exu_issue_ctrl #(.ALUOP_WIDTH(5), .TIMEOUT_CYCLES(8)) dut_t (
    .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready), .in_aluop(t_in_aluop),
    .flush(1'b0), .fu_valid(t_fu_valid), .fu_done(1'b0), .mul_start(t_mul_start),
    .mul_done(t_mul_done), .div_start(t_div_start), .div_signed(t_div_signed), .div_done(1'b0),
    .fu_kill(t_fu_kill), .out_valid(t_out_valid), .out_ready(t_out_ready), .out_sel(t_out_sel),
    .out_timeout(t_out_timeout), .out_illegal(t_out_illegal), .busy(t_busy)
  );

  // Scoreboard: every writeback handshake must match the oldest expected result
  always @(negedge clk) begin
    if (div_start) div_start_seen = 1'b1;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_result got sel=%0d tmo=%0b ill=%0b, expected none", out_sel, out_timeout, out_illegal);
      end else begin
        want = sb.pop_front();
        got  = '{sel: out_sel, tmo: out_timeout, ill: out_illegal};
        if (got !== want) begin
          failures++;
          $display("FAIL sb_result got %b expected %b", got, want);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_aluop = '0; flush = 1'b0; fu_done = 1'b0;
    mul_done = 1'b0; div_done = 1'b0; out_ready = 1'b0;
    t_in_valid = 1'b0; t_in_aluop = '0; t_mul_done = 1'b0; t_out_ready = 1'b0;
    #2;
    checks++;
    if ({in_ready, fu_valid, mul_start, div_start, div_signed, fu_kill, out_valid,
         out_timeout, out_illegal, busy, out_sel} !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b fv=%b ms=%b ds=%b dsg=%b k=%b ov=%b to=%b il=%b b=%b sel=%0d expected all 0",
               in_ready, fu_valid, mul_start, div_start, div_signed, fu_kill, out_valid,
               out_timeout, out_illegal, busy, out_sel);
    end
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got %b expected 1", in_ready); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_aluop = 5'd0; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL single_accept got %b expected 1", in_ready); end
    sb.push_back('{sel: 2'd0, tmo: 1'b0, ill: 1'b0});
    tick(); in_valid = 1'b0;
    checks++;
    if ({fu_valid, mul_start, busy} !== 3'b101) begin failures++; $display("FAIL single_start got fv/ms/busy=%b expected 101", {fu_valid, mul_start, busy}); end
    tick(); fu_done = 1'b1;
    checks++;
    if ({fu_valid, out_valid} !== 2'b00) begin failures++; $display("FAIL single_c2 got fv/ov=%b expected 00", {fu_valid, out_valid}); end
    tick(); fu_done = 1'b0;
    checks++;
    if ({out_valid, out_sel} !== 3'b100) begin failures++; $display("FAIL single_out got ov/sel=%b expected 100", {out_valid, out_sel}); end
    out_ready = 1'b1;
    tick(); out_ready = 1'b0; #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL single_c4 got rdy/ov=%b expected 10", {in_ready, out_valid}); end
  endtask

  task automatic test_mul_ignore();
    in_valid = 1'b1; in_aluop = 5'd15;
    sb.push_back('{sel: 2'd1, tmo: 1'b0, ill: 1'b0});
    tick(); in_valid = 1'b0;
    checks++;
    if ({mul_start, fu_valid} !== 2'b10) begin failures++; $display("FAIL mul_start got ms/fv=%b expected 10", {mul_start, fu_valid}); end
    mul_done = 1'b1;
    tick(); mul_done = 1'b0; fu_done = 1'b1;
    checks++;
    if ({mul_start, out_valid} !== 2'b00) begin failures++; $display("FAIL mul_first_cycle_done got ms/ov=%b expected 00", {mul_start, out_valid}); end
    tick(); fu_done = 1'b0; mul_done = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mul_other_done got ov=%b expected 0", out_valid); end
    tick(); mul_done = 1'b0;
    checks++;
    if ({out_valid, out_sel, out_timeout} !== 4'b1010) begin failures++; $display("FAIL mul_out got %b expected 1010", {out_valid, out_sel, out_timeout}); end
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
  endtask

`ifdef EXU_DIV_EN
  task automatic test_div();
    in_valid = 1'b1; in_aluop = 5'd18;
    sb.push_back('{sel: 2'd3, tmo: 1'b0, ill: 1'b0});
    tick(); in_valid = 1'b0;
    checks++;
    if ({div_start, div_signed} !== 2'b11) begin failures++; $display("FAIL div_start got ds/sg=%b expected 11", {div_start, div_signed}); end
    tick();
    checks++;
    if ({div_start, div_signed} !== 2'b00) begin failures++; $display("FAIL div_start_width got ds/sg=%b expected 00", {div_start, div_signed}); end
    repeat (18) tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL div_early got ov=%b expected 0", out_valid); end
    div_done = 1'b1;
    tick(); div_done = 1'b0;
    checks++;
    if ({out_valid, out_sel, out_timeout, out_illegal} !== 5'b11100) begin failures++; $display("FAIL div_out got %b expected 11100", {out_valid, out_sel, out_timeout, out_illegal}); end
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    in_valid = 1'b1; in_aluop = 5'd17;
    sb.push_back('{sel: 2'd2, tmo: 1'b0, ill: 1'b0});
    tick(); in_valid = 1'b0;
    checks++;
    if ({div_start, div_signed} !== 2'b10) begin failures++; $display("FAIL divu_start got ds/sg=%b expected 10", {div_start, div_signed}); end
    tick(); div_done = 1'b1;
    tick(); div_done = 1'b0;
    checks++;
    if ({out_valid, out_sel} !== 3'b110) begin failures++; $display("FAIL divu_out got ov/sel=%b expected 110", {out_valid, out_sel}); end
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
  endtask
`else
  task automatic test_illegal();
    in_valid = 1'b1; in_aluop = 5'd17;
    sb.push_back('{sel: 2'd2, tmo: 1'b0, ill: 1'b1});
    tick(); in_valid = 1'b0;
    checks++;
    if ({out_valid, out_illegal, out_sel, div_start} !== 5'b11100) begin failures++; $display("FAIL illegal_divu got ov/il/sel/ds=%b expected 11100", {out_valid, out_illegal, out_sel, div_start}); end
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL illegal_drain got ov=%b expected 0", out_valid); end
    in_valid = 1'b1; in_aluop = 5'd19;
    sb.push_back('{sel: 2'd3, tmo: 1'b0, ill: 1'b1});
    tick(); in_valid = 1'b0;
    checks++;
    if ({out_valid, out_illegal, out_sel} !== 4'b1111) begin failures++; $display("FAIL illegal_remu got ov/il/sel=%b expected 1111", {out_valid, out_illegal, out_sel}); end
    out_ready = 1'b1; div_done = 1'b1;
    tick(); out_ready = 1'b0; div_done = 1'b0;
    checks++;
    if ({out_valid, busy} !== 2'b00) begin failures++; $display("FAIL illegal_idle got ov/busy=%b expected 00", {out_valid, busy}); end
  endtask
`endif

  task automatic test_flush_done();
    in_valid = 1'b1; in_aluop = 5'd15;
    tick(); in_valid = 1'b0;
    tick(); flush = 1'b1; mul_done = 1'b1;
    tick(); flush = 1'b0; mul_done = 1'b0;
    checks++;
    if ({fu_kill, busy, out_valid} !== 3'b100) begin failures++; $display("FAIL flush_done_kill got k/busy/ov=%b expected 100", {fu_kill, busy, out_valid}); end
    tick();
    checks++;
    if ({fu_kill, out_valid, in_ready} !== 3'b001) begin failures++; $display("FAIL flush_done_after got k/ov/rdy=%b expected 001", {fu_kill, out_valid, in_ready}); end
  endtask

  task automatic test_flush_resp_idle();
    in_valid = 1'b1; in_aluop = 5'd1;
    tick(); in_valid = 1'b0;
    tick(); fu_done = 1'b1;
    tick(); fu_done = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0;
    checks++;
    if ({out_valid, fu_kill, busy} !== 3'b000) begin failures++; $display("FAIL flush_resp got ov/k/busy=%b expected 000", {out_valid, fu_kill, busy}); end
    in_valid = 1'b1; flush = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_idle_ready got %b expected 0", in_ready); end
    tick(); in_valid = 1'b0; flush = 1'b0;
    checks++;
    if ({busy, fu_valid} !== 2'b00) begin failures++; $display("FAIL flush_idle_state got busy/fv=%b expected 00", {busy, fu_valid}); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_aluop = 5'd3;
    sb.push_back('{sel: 2'd0, tmo: 1'b0, ill: 1'b0});
    tick(); in_valid = 1'b0;
    tick(); fu_done = 1'b1;
    tick(); fu_done = 1'b0;
    in_valid = 1'b1; in_aluop = 5'd15;
    for (int i = 0; i < 5; i++) begin
      fu_done = (i == 1);
      #1;
      checks++;
      if ({out_valid, out_sel, in_ready} !== 4'b1000) begin failures++; $display("FAIL backpressure_hold%0d got ov/sel/rdy=%b expected 1000", i, {out_valid, out_sel, in_ready}); end
      tick();
    end
    fu_done = 1'b0; out_ready = 1'b1; #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin failures++; $display("FAIL handshake_no_accept got ov/rdy=%b expected 10", {out_valid, in_ready}); end
    tick(); out_ready = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL next_accept got %b expected 1", in_ready); end
    sb.push_back('{sel: 2'd1, tmo: 1'b0, ill: 1'b0});
    tick(); in_valid = 1'b0;
    checks++;
    if (mul_start !== 1'b1) begin failures++; $display("FAIL b2b_mul_start got %b expected 1", mul_start); end
    tick(); mul_done = 1'b1;
    tick(); mul_done = 1'b0;
    checks++;
    if ({out_valid, out_sel, out_illegal} !== 4'b1010) begin failures++; $display("FAIL b2b_out got %b expected 1010", {out_valid, out_sel, out_illegal}); end
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_aluop = 5'd15;
    tick(); in_valid = 1'b0;
    rst = 1'b1; #1;
    checks++;
    if ({busy, mul_start, in_ready, fu_kill} !== 4'b0000) begin failures++; $display("FAIL reset_mid got busy/ms/rdy/k=%b expected 0000", {busy, mul_start, in_ready, fu_kill}); end
    tick();
    checks++;
    if ({fu_kill, out_valid} !== 2'b00) begin failures++; $display("FAIL reset_mid_kill got k/ov=%b expected 00", {fu_kill, out_valid}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    t_in_valid = 1'b1; t_in_aluop = 5'd15;
    tick(); t_in_valid = 1'b0;
    repeat (8) tick();
    checks++;
    if ({t_out_valid, t_fu_kill, t_busy} !== 3'b001) begin failures++; $display("FAIL timeout_early got ov/k/busy=%b expected 001", {t_out_valid, t_fu_kill, t_busy}); end
    tick();
    checks++;
    if ({t_out_valid, t_out_timeout, t_fu_kill, t_out_sel} !== 5'b11101) begin failures++; $display("FAIL timeout_fire got ov/to/k/sel=%b expected 11101", {t_out_valid, t_out_timeout, t_fu_kill, t_out_sel}); end
    tick();
    checks++;
    if ({t_fu_kill, t_out_valid, t_out_timeout} !== 3'b011) begin failures++; $display("FAIL timeout_hold got k/ov/to=%b expected 011", {t_fu_kill, t_out_valid, t_out_timeout}); end
    t_out_ready = 1'b1;
    tick(); t_out_ready = 1'b0;
    checks++;
    if (t_out_valid !== 1'b0) begin failures++; $display("FAIL timeout_drain got ov=%b expected 0", t_out_valid); end
  endtask

  task automatic test_done_vs_timeout();
    t_in_valid = 1'b1; t_in_aluop = 5'd15;
    tick(); t_in_valid = 1'b0;
    repeat (8) tick();
    t_mul_done = 1'b1;
    tick(); t_mul_done = 1'b0;
    checks++;
    if ({t_out_valid, t_out_timeout, t_fu_kill} !== 3'b100) begin failures++; $display("FAIL done_beats_timeout got ov/to/k=%b expected 100", {t_out_valid, t_out_timeout, t_fu_kill}); end
    t_out_ready = 1'b1;
    tick(); t_out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_mul_ignore();
`ifdef EXU_DIV_EN
    test_div();
`else
    test_illegal();
`endif
    test_flush_done();
    test_flush_resp_idle();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_done_vs_timeout();
    tick();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got %0d pending expected 0", sb.size()); end
`ifndef EXU_DIV_EN
    checks++;
    if (div_start_seen !== 1'b0) begin failures++; $display("FAIL div_start_tied got %b expected 0", div_start_seen); end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
